// File: rtl/evt_fifo_pkg.sv
// Shared types and helpers for the event-FIFO drain path.
package evt_fifo_pkg;

    localparam int unsigned DEFAULT_READ_LATENCY = 1;
    localparam int unsigned MAX_READ_LATENCY     = 4;

    // One bit per read-pipeline stage; only the low READ_LATENCY bits are ever set.
    typedef logic [MAX_READ_LATENCY-1:0] inflight_vec_t;

    // Pointer increment that wraps at modulus-1 back to 0 (modulus need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned modulus);
        return (ptr + 1 >= modulus) ? 32'd0 : ptr + 1;
    endfunction

endpackage

// File: rtl/evt_skid_buffer.sv
// Circular register FIFO holding read words until the downstream consumer accepts them.
module evt_skid_buffer
    import evt_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         dtype = logic [31:0],
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  dtype             push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output dtype             data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

    dtype             mem_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & (cnt_q != '0);

    // Next-state for pointers and count; flush empties the buffer outright.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) tail_d = PtrW'(wrap_inc(32'(tail_q), DEPTH));
            if (do_pop)  head_d = PtrW'(wrap_inc(32'(head_q), DEPTH));
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer, count and storage registers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (do_push) mem_q[tail_q] <= push_data_i;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[head_q];
    assign count_o = cnt_q;

    // A write into a full buffer is only legal when the head word leaves in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            assert (!(push_i && (cnt_q == CntFull) && !pop_i));
        end
    end

endmodule

// File: rtl/memory_fifo_stream_reader.sv
// Drains an SRAM-backed FIFO into a registered valid/ready stream, popping only against credits.
module memory_fifo_stream_reader
    import evt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int unsigned BUF_DEPTH    = READ_LATENCY + 1,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned CNT_W        = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             fifo_empty_i,
    input  logic             fifo_wr_busy_i,
    output logic             fifo_pop_o,
    input  dtype             fifo_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output dtype             out_data_o,
    output logic [CNT_W-1:0] occupancy_o
);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..4");
    end
    if (BUF_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
        $error("BUF_DEPTH must be at least READ_LATENCY+1");
    end

    localparam inflight_vec_t StageMask = inflight_vec_t'((1 << READ_LATENCY) - 1);

    inflight_vec_t    inflight_q, inflight_d;
    logic [CNT_W-1:0] buf_cnt, inflight_cnt;
    logic             fire, capture;
    int unsigned      credit_used;

    assign fire         = out_valid_o & out_ready_i;
    assign capture      = inflight_q[READ_LATENCY-1] & ~flush_i;
    assign inflight_cnt = CNT_W'($countones(inflight_q));
    assign occupancy_o  = buf_cnt + inflight_cnt;

    // Credit check: a word leaving this cycle frees its slot, so out_ready_i feeds the pop
    // combinationally to keep 1 word/cycle with the minimum buffer depth.
    always_comb begin
        credit_used = 32'(buf_cnt) + 32'(inflight_cnt) - 32'(fire);
        fifo_pop_o  = ~fifo_empty_i & ~fifo_wr_busy_i & ~flush_i & rst_ni
                    & (credit_used < BUF_DEPTH);
    end

    // Read-latency tracker: shift in each pop, drop everything on flush.
    always_comb begin
        inflight_d = {inflight_q[MAX_READ_LATENCY-2:0], fifo_pop_o} & StageMask;
        if (flush_i) inflight_d = '0;
    end

    // In-flight register; clearing it on reset makes late read data from old pops harmless.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) inflight_q <= '0;
        else         inflight_q <= inflight_d;
    end

    evt_skid_buffer #(
        .DEPTH (BUF_DEPTH),
        .dtype (dtype),
        .CNT_W (CNT_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (capture),
        .push_data_i (fifo_data_i),
        .pop_i       (fire),
        .valid_o     (out_valid_o),
        .data_o      (out_data_o),
        .count_o     (buf_cnt)
    );

    // The memory port must never see a pop while empty or while a write owns it.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(fifo_pop_o && (fifo_empty_i || fifo_wr_busy_i)));
        end
    end

endmodule

// File: tb/tb_memory_fifo_stream_reader.sv
// Randomised bench for memory_fifo_stream_reader against a queue-based reference model.
module tb_memory_fifo_stream_reader;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: READ_LATENCY=1/BUF_DEPTH=2, index 1: READ_LATENCY=3/BUF_DEPTH=4.
    logic          rst_n [2];
    logic          flush [2];
    logic          empty [2];
    logic          busy  [2];
    logic          ready [2];
    logic          pop   [2];
    logic          valid [2];
    logic [DW-1:0] fdata [2];
    logic [DW-1:0] odata [2];
    logic [1:0]    occ0;
    logic [2:0]    occ1;

    memory_fifo_stream_reader #(
        .DATA_WIDTH   (DW),
        .READ_LATENCY (1),
        .BUF_DEPTH    (2)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n[0]),
        .flush_i        (flush[0]),
        .fifo_empty_i   (empty[0]),
        .fifo_wr_busy_i (busy[0]),
        .fifo_pop_o     (pop[0]),
        .fifo_data_i    (fdata[0]),
        .out_valid_o    (valid[0]),
        .out_ready_i    (ready[0]),
        .out_data_o     (odata[0]),
        .occupancy_o    (occ0)
    );

    memory_fifo_stream_reader #(
        .DATA_WIDTH   (DW),
        .READ_LATENCY (3),
        .BUF_DEPTH    (4)
    ) u_dut_lat3 (
        .clk_i          (clk),
        .rst_ni         (rst_n[1]),
        .flush_i        (flush[1]),
        .fifo_empty_i   (empty[1]),
        .fifo_wr_busy_i (busy[1]),
        .fifo_pop_o     (pop[1]),
        .fifo_data_i    (fdata[1]),
        .out_valid_o    (valid[1]),
        .out_ready_i    (ready[1]),
        .out_data_o     (odata[1]),
        .occupancy_o    (occ1)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int            sel, lat, depth, cyc, max_occ, busy_pops;
    logic          after_reset;
    logic [DW-1:0] mem_q     [$];   // contents of the memory FIFO
    logic [DW-1:0] exp_q     [$];   // words that should sit in the output buffer
    logic [DW-1:0] delivered [$];   // words accepted downstream
    int            pop_cyc   [$];
    int            fire_cyc  [$];
    logic [DW-1:0] drive_at  [int]; // memory read data by cycle
    logic [DW-1:0] pend_at   [int]; // words still expected to land, by arrival cycle

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) mem_q.push_back(DW'(base + i));
    endtask

    task automatic clear_logs();
        delivered.delete();
        pop_cyc.delete();
        fire_cyc.delete();
        busy_pops = 0;
        max_occ   = 0;
    endtask

    task automatic check_seq(input string tag, input int base, input int n);
        chk({tag, "_count"}, 64'(delivered.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < delivered.size()) chk(tag, delivered[i], DW'(base + i));
        end
    endtask

    // Sample the state just after the next active edge, with inputs still held.
    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rdy, input logic bsy, input logic fl, input logic rst);
        int            occ_m;
        logic          exp_fire, exp_pop, is_empty;
        logic [2:0]    occ_act;
        logic [DW-1:0] w;
        @(negedge clk);
        is_empty   = (mem_q.size() == 0);
        ready[sel] = rdy;
        busy[sel]  = bsy;
        flush[sel] = fl;
        rst_n[sel] = ~rst;
        empty[sel] = is_empty;
        fdata[sel] = drive_at.exists(cyc) ? drive_at[cyc] : DW'($urandom);
        #1;
        occ_act  = (sel == 1) ? occ1 : {1'b0, occ0};
        occ_m    = exp_q.size() + pend_at.num();
        exp_fire = (exp_q.size() != 0) && rdy;
        exp_pop  = !is_empty && !bsy && !fl && !rst && ((occ_m - int'(exp_fire)) < depth);
        chk("out_valid", valid[sel], exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_data", odata[sel], exp_q[0]);
        else if (after_reset)  chk("out_data_after_reset", odata[sel], 0);
        chk("occupancy", occ_act, occ_m);
        chk("fifo_pop", pop[sel], exp_pop);
        if (int'(occ_act) > max_occ) max_occ = int'(occ_act);
        after_reset = rst;
        if (exp_fire) begin
            delivered.push_back(exp_q.pop_front());
            fire_cyc.push_back(cyc);
        end
        if (pop[sel]) begin
            pop_cyc.push_back(cyc);
            if (bsy) busy_pops++;
            if (mem_q.size() != 0) begin
                w = mem_q.pop_front();
                drive_at[cyc + lat] = w;
                pend_at[cyc + lat]  = w;
            end
        end
        if (pend_at.exists(cyc)) begin
            if (!fl && !rst) exp_q.push_back(pend_at[cyc]);
            pend_at.delete(cyc);
        end
        if (fl || rst) begin
            exp_q.delete();
            pend_at.delete();
        end
        drive_at.delete(cyc);
        cyc++;
    endtask

    initial begin
        int start;
        int stall_pops;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            flush[i] = 1'b0;
            empty[i] = 1'b1;
            busy[i]  = 1'b0;
            ready[i] = 1'b1;
            fdata[i] = '0;
        end
        sel = 0; lat = 1; depth = 2; cyc = 0; after_reset = 1'b0;
        clear_logs();

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_valid", valid[i], 0);
            chk("reset_data", odata[i], 0);
            chk("reset_pop", pop[i], 0);
        end
        chk("reset_occ0", occ0, 0);
        chk("reset_occ1", occ1, 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Three words, always ready: pops at +0,+1,+2 and output two cycles later.
        clear_logs();
        load(32'h10, 3);
        start = cyc;
        repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_pop_count", 64'(pop_cyc.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < pop_cyc.size())  chk("t1_pop_cycle", 64'(pop_cyc[i] - start), 64'(i));
            if (i < fire_cyc.size()) chk("t1_out_cycle", 64'(fire_cyc[i] - start), 64'(i + 2));
        end
        check_seq("t1_order", 32'h10, 3);
        chk("t1_max_occ_le2", 64'(max_occ <= 2), 1);

        // Backpressure: exactly BUF_DEPTH pops during the stall, then full-rate drain.
        clear_logs();
        load(32'h10, 10);
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
        stall_pops = pop_cyc.size();
        chk("t2_stall_pops", 64'(stall_pops), 2);
        for (int k = 0; k < 30 && delivered.size() < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_seq("t2_order", 32'h10, 10);
        if (fire_cyc.size() == 10) chk("t2_rate", 64'(fire_cyc[9] - fire_cyc[0]), 9);

        // Write port busy on alternate cycles.
        clear_logs();
        load(32'h100, 20);
        for (int k = 0; k < 120 && delivered.size() < 20; k++) begin
            step(1'b1, 1'((k % 2) == 0), 1'b0, 1'b0);
        end
        check_seq("t3_order", 32'h100, 20);
        chk("t3_busy_pops", 64'(busy_pops), 0);

        // Flush with one word buffered and one read returning in the flush cycle.
        clear_logs();
        load(32'hA0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        load(32'hA1, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        mem_q.delete();
        peek();
        chk("t4_valid_after_flush", valid[0], 0);
        chk("t4_occ_after_flush", occ0, 0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_dropped", 64'(delivered.size()), 0);

        // Reset mid-operation, then resume on fresh words.
        clear_logs();
        load(32'hB0, 4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        mem_q.delete();
        peek();
        chk("t5_valid_after_reset", valid[0], 0);
        chk("t5_data_after_reset", odata[0], 0);
        chk("t5_occ_after_reset", occ0, 0);
        load(32'hC0, 3);
        for (int k = 0; k < 12 && delivered.size() < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_seq("t5_resume", 32'hC0, 3);

        // Longer read latency with random backpressure.
        sel = 1; lat = 3; depth = 4; after_reset = 1'b0;
        clear_logs();
        load(32'h200, 16);
        for (int k = 0; k < 300 && delivered.size() < 16; k++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        check_seq("t6_order", 32'h200, 16);
        chk("t6_max_occ_le4", 64'(max_occ <= 4), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
